// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// mem_port_arbiter
//   Shares one single-port memory between instruction fetch and data ports.
//   Data wins by default; a starvation counter forces fetch through
//   periodically; data_lock gives the data port exclusive multi-access
//   ownership of the memory.
// Revision: 1.0
// ============================================================================
module mem_port_arbiter #(
   parameter int ADDR_W       = 30,
   parameter int DATA_W       = 32,
   parameter int STARVE_LIMIT = 4,
   parameter int CNT_W        = 3,
   localparam int MASK_W      = DATA_W / 8
) (
   input  logic              clk_i,
   input  logic              async_rst_n_i,
   // instruction fetch port
   input  logic              inst_req_i,
   input  logic [ADDR_W-1:0] inst_address_i,
   output logic              inst_ack_o,
   output logic [DATA_W-1:0] inst_rdata_o,
   // data port
   input  logic              data_req_i,
   input  logic              data_lock_i,
   input  logic              data_we_i,
   input  logic [ADDR_W-1:0] data_address_i,
   input  logic [MASK_W-1:0] data_mask_i,
   input  logic [DATA_W-1:0] data_wdata_i,
   output logic              data_ack_o,
   output logic [DATA_W-1:0] data_rdata_o,
   // memory port
   output logic              mem_req_o,
   output logic              mem_we_o,
   output logic [ADDR_W-1:0] mem_addr_o,
   output logic [MASK_W-1:0] mem_mask_o,
   output logic [DATA_W-1:0] mem_wdata_o,
   input  logic [DATA_W-1:0] mem_rdata_i,
   input  logic              mem_ack_i
);

   typedef enum logic [1:0] {
      S_IDLE      = 2'd0,
      S_INST_BUSY = 2'd1,
      S_DATA_BUSY = 2'd2,
      S_LOCKED    = 2'd3
   } state_e;

   localparam logic [CNT_W-1:0] c_starve_limit = CNT_W'(STARVE_LIMIT);
   localparam logic [CNT_W-1:0] c_cnt_max      = '1;

   state_e            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              mem_req_q, mem_req_d;
   logic              mem_we_q, mem_we_d;
   logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
   logic [MASK_W-1:0] mem_mask_q, mem_mask_d;
   logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
   logic              inst_ack_q, inst_ack_d;
   logic [DATA_W-1:0] inst_rdata_q, inst_rdata_d;
   logic              data_ack_q, data_ack_d;
   logic [DATA_W-1:0] data_rdata_q, data_rdata_d;

   logic w_inst_eff;
   logic w_data_eff;
   logic w_force_inst;
   logic w_grant_inst;
   logic w_grant_data;

   // A requester is ignored during its own ack cycle, since its request line
   // is still high while the core reacts to the ack.
   assign w_inst_eff   = inst_req_i & ~inst_ack_q;
   assign w_data_eff   = data_req_i & ~data_ack_q;
   assign w_force_inst = (STARVE_LIMIT != 0) && (cnt_q == c_starve_limit) && w_inst_eff;

   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      mem_req_d    = mem_req_q;
      mem_we_d     = mem_we_q;
      mem_addr_d   = mem_addr_q;
      mem_mask_d   = mem_mask_q;
      mem_wdata_d  = mem_wdata_q;
      inst_ack_d   = 1'b0;
      inst_rdata_d = inst_rdata_q;
      data_ack_d   = 1'b0;
      data_rdata_d = data_rdata_q;
      w_grant_inst = 1'b0;
      w_grant_data = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (!inst_req_i) begin
               cnt_d = '0;
            end
            if (w_data_eff && !w_force_inst) begin
               w_grant_data = 1'b1;
            end else if (w_inst_eff) begin
               w_grant_inst = 1'b1;
            end
         end
         S_LOCKED: begin
            if (w_data_eff) begin
               w_grant_data = 1'b1;
            end else if (!data_lock_i) begin
               state_d = S_IDLE;
            end
         end
         S_INST_BUSY: begin
            if (mem_ack_i) begin
               mem_req_d    = 1'b0;
               inst_ack_d   = 1'b1;
               inst_rdata_d = mem_rdata_i;
               state_d      = S_IDLE;
            end
         end
         S_DATA_BUSY: begin
            if (mem_ack_i) begin
               mem_req_d  = 1'b0;
               data_ack_d = 1'b1;
               if (!mem_we_q) begin
                  data_rdata_d = mem_rdata_i;
               end
               state_d = data_lock_i ? S_LOCKED : S_IDLE;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      if (w_grant_data) begin
         state_d     = S_DATA_BUSY;
         mem_req_d   = 1'b1;
         mem_we_d    = data_we_i;
         mem_addr_d  = data_address_i;
         mem_mask_d  = data_mask_i;
         mem_wdata_d = data_wdata_i;
         if (inst_req_i && (cnt_q != c_cnt_max)) begin
            cnt_d = cnt_q + 1'b1;
         end
      end

      if (w_grant_inst) begin
         state_d    = S_INST_BUSY;
         mem_req_d  = 1'b1;
         mem_we_d   = 1'b0;
         mem_addr_d = inst_address_i;
         mem_mask_d = '1;
         cnt_d      = '0;
      end
   end

   always_ff @(posedge clk_i or negedge async_rst_n_i) begin
      if (!async_rst_n_i) begin
         state_q      <= S_IDLE;
         cnt_q        <= '0;
         mem_req_q    <= 1'b0;
         mem_we_q     <= 1'b0;
         mem_addr_q   <= '0;
         mem_mask_q   <= '0;
         mem_wdata_q  <= '0;
         inst_ack_q   <= 1'b0;
         inst_rdata_q <= '0;
         data_ack_q   <= 1'b0;
         data_rdata_q <= '0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         mem_req_q    <= mem_req_d;
         mem_we_q     <= mem_we_d;
         mem_addr_q   <= mem_addr_d;
         mem_mask_q   <= mem_mask_d;
         mem_wdata_q  <= mem_wdata_d;
         inst_ack_q   <= inst_ack_d;
         inst_rdata_q <= inst_rdata_d;
         data_ack_q   <= data_ack_d;
         data_rdata_q <= data_rdata_d;
      end
   end

   assign inst_ack_o   = inst_ack_q;
   assign inst_rdata_o = inst_rdata_q;
   assign data_ack_o   = data_ack_q;
   assign data_rdata_o = data_rdata_q;
   assign mem_req_o    = mem_req_q;
   assign mem_we_o     = mem_we_q;
   assign mem_addr_o   = mem_addr_q;
   assign mem_mask_o   = mem_mask_q;
   assign mem_wdata_o  = mem_wdata_q;

endmodule
`default_nettype wire
